fb_scanout_arbiter: RTL and testbench
=====================================

// Module: fb_scanout_arbiter
// PURPOSE
//  Shares the single framebuffer memory port between VGA scanout (read) and the drawing
//  engine (write). Scanout bursts prefetch into a show-ahead pixel FIFO that the VGA timing
//  block drains one word per visible pixel; draw writes use the idle memory slots.
//  Sits between the VGA timing generator and the SDRAM controller.
// PARAMETERS
//  ADDR_W         22      memory word address width
//  FRAME_WORDS    307200  words per frame (640*480); scan address range [0,FRAME_WORDS)
//  FIFO_DEPTH     256     pixel FIFO depth in words, power of 2
//  BURST          32      words per scanout read burst, power of 2, <= FIFO_DEPTH/2
//  MAX_RD_STREAK  4       consecutive read bursts allowed while a write waits
// PORTS
//  iCLK               in   1       pixel clock; all logic on posedge
//  iRST_N             in   1       asynchronous active-low reset
//  iTopOfScreen       in   1       1-cycle pulse at top of blank screen: frame restart
//  iPixelRequest      in   1       pop one pixel this cycle (visible pixel)
//  oPixel             out  12      FIFO head {R,G,B} 4:4:4; 0 when FIFO empty
//  oUnderflow         out  1       1-cycle pulse: pop while FIFO empty
//  iWrAddress         in   ADDR_W  draw write address
//  iWrData            in   16      draw write data
//  iWrValid           in   1       draw write pending
//  oWrReady           out  1       write accepted this cycle (valid&ready = transfer)
//  oMemAddress        out  ADDR_W  memory address
//  oMemRead           out  1       read burst request
//  oMemWrite          out  1       single-word write request
//  oMemWriteData      out  16      write data
//  oMemBurstCount     out  6       BURST for reads, 1 for writes
//  iMemWaitRequest    in   1       memory stall; request held stable while 1
//  iMemReadData       in   16      read return data
//  iMemReadDataValid  in   1       read return strobe, in request order
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; scan address 0; state IDLE; streak, in-flight, discard = 0.
//  Credit: inflight = words requested, not yet returned. Read eligible when
//   scan_addr < FRAME_WORDS and FIFO_DEPTH - (level + inflight) >= BURST. Overflow impossible.
//  FSM IDLE/RD/WR:
//   IDLE: read eligible and (!iWrValid or streak < MAX_RD_STREAK) -> RD; else iWrValid -> WR.
//   RD: oMemRead=1, addr=scan_addr, burst=BURST. When !iMemWaitRequest: scan_addr += BURST,
//       inflight += BURST, streak++ if iWrValid, -> IDLE.
//   WR: iWrAddress/iWrData registered on IDLE->WR (oWrReady=1 that cycle); oMemWrite=1
//       until !iMemWaitRequest, then streak=0, -> IDLE.
//   Request accepted at most once per entry; ≥1 IDLE cycle between requests.
//  Return: each iMemReadDataValid decrements inflight. If discard > 0, the word is dropped
//   and discard decrements; otherwise low 12 bits are pushed.
//  Pop: iPixelRequest with FIFO non-empty pops; oPixel shows the next head one cycle later.
//   Pop when empty: no state change, oPixel=0, oUnderflow=1 next cycle.
//  Simultaneous push and pop: level unchanged; push into empty FIFO visible the next cycle.
//  iTopOfScreen: FIFO flushed, scan_addr=0, discard=inflight plus any return in the same
//   cycle; an RD/WR in progress still completes (no request abort). Pops in that cycle ignored.
//  End of frame: scan_addr reaches FRAME_WORDS -> no more reads; writes get every slot.
//  Widths: scan_addr ADDR_W bits, no wrap; level/inflight/discard log2(FIFO_DEPTH)+1 bits.
//  Async reset mid-burst: memory controller is reset on the same iRST_N; no drain.
// STRUCTURE
//  Package fb_pkg: H_ACT=640, V_ACT=480, FRAME_WORDS, RGB444 pack/unpack functions,
//   FSM state typedef {IDLE,RD,WR}.
//  Sub-module fb_pixel_fifo: synchronous show-ahead FIFO with level output and flush input.
//  Top contains FSM, credit/discard counters, write holding register.
// TESTING
//  1 Reset, no pops, memory stall 0: exactly FIFO_DEPTH/BURST=8 bursts at 0,32..224, then
//    idle until a pop; level reaches 256.
//  2 Continuous pops at 1/clk after fill: refill bursts keep level > 0, oUnderflow never 1;
//    last burst address 307168, none after.
//  3 iWrValid held during fill: write issued after 4 read bursts, then reads resume; write
//    addr/data on memory match inputs; oWrReady pulses once per write.
//  4 iTopOfScreen with 64 words in flight: those 64 returns dropped, first pushed word is
//    from address 0, oPixel matches memory word 0.
//  5 iMemWaitRequest=1 for 10 cycles during RD: address/burst/read held stable, one burst.
//  6 Pop on empty FIFO: oUnderflow 1-cycle pulse, oPixel=0, level stays 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants, pixel format helpers and arbiter state encoding
// for the framebuffer scanout path.
package fb_pkg;

  localparam int H_ACT       = 640;
  localparam int V_ACT       = 480;
  localparam int FRAME_WORDS = H_ACT * V_ACT;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef logic [1:0] fb_state_t;
  localparam fb_state_t ST_IDLE = 2'd0;
  localparam fb_state_t ST_RD   = 2'd1;
  localparam fb_state_t ST_WR   = 2'd2;

  function automatic rgb444_t rgb444_unpack(input logic [11:0] w);
    return rgb444_t'(w);
  endfunction

  function automatic logic [11:0] rgb444_pack(input rgb444_t p);
    return {p.r, p.g, p.b};
  endfunction

endpackage

// File: rtl/fb_pixel_fifo.sv
// Show-ahead pixel FIFO: the head word is presented combinationally,
// zero while empty. Pops on an empty FIFO are ignored; flush wins over everything.
module fb_pixel_fifo #(
  parameter int DEPTH = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fb_pkg::rgb444_t            data_i,
  input  logic                       pop_i,
  output fb_pkg::rgb444_t            head_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  import fb_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rgb444_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   level_q;
  logic               do_pop;

  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? rgb444_t'('0) : mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Arbitrates the framebuffer memory port between credit-limited scanout
// read bursts and single-word draw writes.
module fb_scanout_arbiter #(
  parameter int ADDR_W        = 22,
  parameter int FRAME_WORDS   = fb_pkg::FRAME_WORDS,
  parameter int FIFO_DEPTH    = 256,
  parameter int BURST         = 32,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iTopOfScreen,
  input  logic              iPixelRequest,
  output logic [11:0]       oPixel,
  output logic              oUnderflow,
  input  logic [ADDR_W-1:0] iWrAddress,
  input  logic [15:0]       iWrData,
  input  logic              iWrValid,
  output logic              oWrReady,
  output logic [ADDR_W-1:0] oMemAddress,
  output logic              oMemRead,
  output logic              oMemWrite,
  output logic [15:0]       oMemWriteData,
  output logic [5:0]        oMemBurstCount,
  input  logic              iMemWaitRequest,
  input  logic [15:0]       iMemReadData,
  input  logic              iMemReadDataValid
);
  import fb_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int STR_W = $clog2(MAX_RD_STREAK + 1);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  fb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d, mem_addr_q, mem_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d, discard_q, discard_d;
  logic [STR_W-1:0]  streak_q, streak_d;
  logic              stale_q, stale_d, underflow_q, underflow_d;
  logic              wr_ready, rd_accept, rd_eligible, push, fifo_empty;
  logic [CNT_W-1:0]  level;
  logic [CNT_W:0]    committed;
  rgb444_t           head;
  logic              unused_hi;

  assign unused_hi   = &{1'b0, iMemReadData[15:12]};
  assign committed   = {1'b0, level} + {1'b0, inflight_q};
  assign rd_eligible = (scan_addr_q < ADDR_W'(FRAME_WORDS)) &&
                       (committed + (CNT_W+1)'(BURST) <= (CNT_W+1)'(FIFO_DEPTH));
  assign rd_accept   = (state_q == ST_RD) && !iMemWaitRequest;
  assign push        = iMemReadDataValid && (discard_q == '0) && !iTopOfScreen;
  assign underflow_d = iPixelRequest && fifo_empty && !iTopOfScreen;

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    wr_data_d   = wr_data_q;
    streak_d    = streak_q;
    scan_addr_d = scan_addr_q;
    discard_d   = discard_q;
    stale_d     = stale_q;
    wr_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_eligible && !iTopOfScreen &&
            (!iWrValid || streak_q < STR_W'(MAX_RD_STREAK))) begin
          state_d    = ST_RD;
          mem_addr_d = scan_addr_q;
        end else if (iWrValid) begin
          state_d    = ST_WR;
          mem_addr_d = iWrAddress;
          wr_data_d  = iWrData;
          wr_ready   = 1'b1;
        end
      end
      ST_RD: begin
        if (!iMemWaitRequest) begin
          state_d = ST_IDLE;
          if (iWrValid && streak_q < STR_W'(MAX_RD_STREAK)) streak_d = streak_q + STR_W'(1);
        end
      end
      ST_WR: begin
        if (!iMemWaitRequest) begin
          state_d  = ST_IDLE;
          streak_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    inflight_d = inflight_q + (rd_accept ? BURST_C : '0) - (iMemReadDataValid ? CNT_W'(1) : '0);

    // A burst still waiting when the frame restarts fetches stale data:
    // it completes, but its words join the discard count instead of advancing the scan.
    if (iTopOfScreen) begin
      scan_addr_d = '0;
      discard_d   = inflight_d;
      stale_d     = (state_q == ST_RD) && iMemWaitRequest;
    end else begin
      if (rd_accept) begin
        if (stale_q) discard_d = discard_d + BURST_C;
        else         scan_addr_d = scan_addr_q + ADDR_W'(BURST);
        stale_d = 1'b0;
      end
      if (iMemReadDataValid && discard_q != '0) discard_d = discard_d - CNT_W'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      scan_addr_q <= '0;
      mem_addr_q  <= '0;
      wr_data_q   <= '0;
      inflight_q  <= '0;
      discard_q   <= '0;
      streak_q    <= '0;
      stale_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_addr_q <= scan_addr_d;
      mem_addr_q  <= mem_addr_d;
      wr_data_q   <= wr_data_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      streak_q    <= streak_d;
      stale_q     <= stale_d;
      underflow_q <= underflow_d;
    end
  end

  fb_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (iCLK),
    .rst_ni  (iRST_N),
    .flush_i (iTopOfScreen),
    .push_i  (push),
    .data_i  (rgb444_unpack(iMemReadData[11:0])),
    .pop_i   (iPixelRequest && !iTopOfScreen),
    .head_o  (head),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign oPixel         = rgb444_pack(head);
  assign oUnderflow     = underflow_q;
  assign oWrReady       = wr_ready;
  assign oMemRead       = (state_q == ST_RD);
  assign oMemWrite      = (state_q == ST_WR);
  assign oMemAddress    = (state_q == ST_IDLE) ? '0 : mem_addr_q;
  assign oMemWriteData  = (state_q == ST_WR) ? wr_data_q : '0;
  assign oMemBurstCount = (state_q == ST_RD) ? 6'(BURST) :
                          (state_q == ST_WR) ? 6'd1 : 6'd0;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Directed bench for fb_scanout_arbiter with a small memory model whose
// word at address a is 16'hC000 | (3a+1); frame shortened to 1024 words.
module tb_fb_scanout_arbiter;

  localparam int ADDR_W = 22;
  localparam int FRAME  = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tos = 1'b0, pix_req = 1'b0;
  logic [11:0]       pixel;
  logic              underflow;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [15:0]       wr_data = '0;
  logic              wr_valid = 1'b0, wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd, mem_wr;
  logic [15:0]       mem_wdata;
  logic [5:0]        mem_bc;
  logic              stall = 1'b0;
  logic [15:0]       rdata = '0;
  logic              rvalid = 1'b0;

  int pass_cnt = 0, total_cnt = 0;
  bit ret_en = 1'b0;
  int pend_q[$];
  int rd_log[$];
  int op_log[$];
  int wa_log[$];
  int wd_log[$];
  int n_rd = 0, n_wr = 0, n_ready = 0, n_uf = 0, last_rd = -1;

  fb_scanout_arbiter #(.ADDR_W(ADDR_W), .FRAME_WORDS(FRAME)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iTopOfScreen(tos), .iPixelRequest(pix_req),
    .oPixel(pixel), .oUnderflow(underflow),
    .iWrAddress(wr_addr), .iWrData(wr_data), .iWrValid(wr_valid), .oWrReady(wr_ready),
    .oMemAddress(mem_addr), .oMemRead(mem_rd), .oMemWrite(mem_wr),
    .oMemWriteData(mem_wdata), .oMemBurstCount(mem_bc),
    .iMemWaitRequest(stall), .iMemReadData(rdata), .iMemReadDataValid(rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input int a);
    return 16'hC000 | 16'(a * 3 + 1);
  endfunction

  function automatic logic [11:0] pix(input int a);
    return 12'(a * 3 + 1);
  endfunction

  // Memory model and event counters, evaluated on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_q.delete();
      rvalid = 1'b0;
      rdata  = '0;
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
      if (ret_en && pend_q.size() > 0) begin
        rvalid = 1'b1;
        rdata  = mem_word(pend_q.pop_front());
      end
      if (mem_rd && !stall) begin
        for (int i = 0; i < 32; i++) pend_q.push_back(int'(mem_addr) + i);
        rd_log.push_back(int'(mem_addr));
        op_log.push_back(int'(mem_addr));
        last_rd = int'(mem_addr);
        n_rd++;
      end
      if (mem_wr && !stall) begin
        wa_log.push_back(int'(mem_addr));
        wd_log.push_back(int'(mem_wdata));
        op_log.push_back(-1);
        n_wr++;
      end
      if (wr_ready)  n_ready++;
      if (underflow) n_uf++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic st, input bit ren);
    rst_n = 1'b0;
    stall = st; ret_en = ren; tos = 1'b0; pix_req = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_log.delete(); op_log.delete(); wa_log.delete(); wd_log.delete();
    n_rd = 0; n_wr = 0; n_ready = 0; n_uf = 0; last_rd = -1;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    rst_n = 1'b0;
    tick(1);
    total_cnt++; if (mem_rd !== 1'b0) $display("FAIL reset_rd got %b want 0", mem_rd); else pass_cnt++;
    total_cnt++; if (mem_wr !== 1'b0) $display("FAIL reset_wr got %b want 0", mem_wr); else pass_cnt++;
    total_cnt++; if (mem_addr !== '0) $display("FAIL reset_addr got %0h want 0", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_bc !== 6'd0) $display("FAIL reset_bc got %0d want 0", mem_bc); else pass_cnt++;
    total_cnt++; if (pixel !== 12'h0) $display("FAIL reset_pixel got %0h want 0", pixel); else pass_cnt++;
    total_cnt++; if ({underflow, wr_ready} !== 2'b00) $display("FAIL reset_flags got %b want 00", {underflow, wr_ready}); else pass_cnt++;
    $display("reset: outputs checked");
  endtask

  task automatic test_fill();
    do_reset(1'b0, 1'b1);
    tick(300);
    total_cnt++; if (n_rd !== 8) $display("FAIL fill_bursts got %0d want 8", n_rd); else pass_cnt++;
    for (int i = 0; i < 8 && i < rd_log.size(); i++) begin
      total_cnt++;
      if (rd_log[i] !== 32 * i) $display("FAIL fill_addr%0d got %0d want %0d", i, rd_log[i], 32 * i);
      else pass_cnt++;
    end
    tick(50);
    total_cnt++; if (n_rd !== 8) $display("FAIL fill_idle got %0d want 8", n_rd); else pass_cnt++;
    total_cnt++; if (pixel !== pix(0)) $display("FAIL fill_head got %0h want %0h", pixel, pix(0)); else pass_cnt++;
    $display("fill: %0d bursts, last addr %0d", n_rd, last_rd);
  endtask

  task automatic test_stream();
    for (int k = 0; k < FRAME; k++) begin
      total_cnt++;
      if (pixel !== pix(k)) $display("FAIL stream_pix%0d got %0h want %0h", k, pixel, pix(k));
      else pass_cnt++;
      pix_req = 1'b1;
      tick(1);
    end
    pix_req = 1'b0;
    tick(20);
    total_cnt++; if (n_uf !== 0) $display("FAIL stream_underflow got %0d want 0", n_uf); else pass_cnt++;
    total_cnt++; if (last_rd !== FRAME - 32) $display("FAIL stream_last_addr got %0d want %0d", last_rd, FRAME - 32); else pass_cnt++;
    total_cnt++; if (n_rd !== FRAME / 32) $display("FAIL stream_bursts got %0d want %0d", n_rd, FRAME / 32); else pass_cnt++;
    total_cnt++; if (pixel !== 12'h0) $display("FAIL stream_empty got %0h want 0", pixel); else pass_cnt++;
    $display("stream: %0d pixels popped, %0d bursts", FRAME, n_rd);
  endtask

  task automatic test_write_priority();
    int exp_ops[10] = '{0, 32, 64, 96, -1, 128, 160, 192, 224, -1};
    int widx = 0;
    bit ready_prev = 1'b0;
    do_reset(1'b0, 1'b1);
    wr_valid = 1'b1; wr_addr = 22'h012345; wr_data = 16'hBEEF;
    for (int c = 0; c < 300 && widx < 2; c++) begin
      tick(1);
      if (ready_prev) begin
        widx++;
        if (widx == 1) begin wr_addr = 22'h3FFFFF; wr_data = 16'h1234; end
        else wr_valid = 1'b0;
      end
      ready_prev = wr_ready;
    end
    total_cnt++; if (widx !== 2) $display("FAIL wr_timeout got %0d want 2 writes", widx); else pass_cnt++;
    tick(100);
    total_cnt++; if (op_log.size() !== 10) $display("FAIL wr_op_count got %0d want 10", op_log.size()); else pass_cnt++;
    for (int i = 0; i < 10 && i < op_log.size(); i++) begin
      total_cnt++;
      if (op_log[i] !== exp_ops[i]) $display("FAIL wr_op%0d got %0d want %0d", i, op_log[i], exp_ops[i]);
      else pass_cnt++;
    end
    total_cnt++; if (n_ready !== 2) $display("FAIL wr_ready_pulses got %0d want 2", n_ready); else pass_cnt++;
    if (wa_log.size() == 2) begin
      total_cnt++; if (wa_log[0] !== 32'h12345 || wd_log[0] !== 32'hBEEF) $display("FAIL wr0 got %0h/%0h want 12345/beef", wa_log[0], wd_log[0]); else pass_cnt++;
      total_cnt++; if (wa_log[1] !== 32'h3FFFFF || wd_log[1] !== 32'h1234) $display("FAIL wr1 got %0h/%0h want 3fffff/1234", wa_log[1], wd_log[1]); else pass_cnt++;
    end else begin
      total_cnt++; $display("FAIL wr_count got %0d want 2", wa_log.size());
    end
    $display("write_priority: %0d ops, %0d writes", op_log.size(), n_wr);
  endtask

  task automatic test_flush();
    do_reset(1'b1, 1'b0);
    tick(2);
    stall = 1'b0; tick(1); stall = 1'b1;
    tick(3);
    stall = 1'b0; tick(1); stall = 1'b1;
    tick(3);
    total_cnt++; if (n_rd !== 2) $display("FAIL flush_inflight got %0d bursts want 2", n_rd); else pass_cnt++;
    tos = 1'b1; tick(1); tos = 1'b0;
    stall = 1'b0; ret_en = 1'b1;
    tick(500);
    total_cnt++; if (rd_log.size() < 4 || rd_log[2] !== 64) $display("FAIL flush_pending_burst got %0d want 64", rd_log.size() > 2 ? rd_log[2] : -1); else pass_cnt++;
    total_cnt++; if (rd_log.size() < 4 || rd_log[3] !== 0) $display("FAIL flush_restart got %0d want 0", rd_log.size() > 3 ? rd_log[3] : -1); else pass_cnt++;
    total_cnt++; if (pixel !== pix(0)) $display("FAIL flush_first_pixel got %0h want %0h", pixel, pix(0)); else pass_cnt++;
    pix_req = 1'b1; tick(1); pix_req = 1'b0;
    total_cnt++; if (pixel !== pix(1)) $display("FAIL flush_second_pixel got %0h want %0h", pixel, pix(1)); else pass_cnt++;
    $display("flush: %0d bursts after restart", n_rd);
  endtask

  task automatic test_stall();
    do_reset(1'b1, 1'b0);
    tick(1);
    for (int c = 0; c < 10; c++) begin
      total_cnt++;
      if (mem_rd !== 1'b1 || mem_addr !== '0 || mem_bc !== 6'd32)
        $display("FAIL stall_hold%0d got rd=%b addr=%0d bc=%0d want 1/0/32", c, mem_rd, mem_addr, mem_bc);
      else pass_cnt++;
      tick(1);
    end
    total_cnt++; if (n_rd !== 0) $display("FAIL stall_no_accept got %0d want 0", n_rd); else pass_cnt++;
    stall = 1'b0; tick(1); stall = 1'b1;
    tick(5);
    total_cnt++; if (n_rd !== 1) $display("FAIL stall_one_burst got %0d want 1", n_rd); else pass_cnt++;
    total_cnt++; if (mem_addr !== 22'd32) $display("FAIL stall_next_addr got %0d want 32", mem_addr); else pass_cnt++;
    $display("stall: %0d burst accepted", n_rd);
  endtask

  task automatic test_underflow();
    do_reset(1'b1, 1'b0);
    tick(2);
    total_cnt++; if (underflow !== 1'b0) $display("FAIL uf_idle got %b want 0", underflow); else pass_cnt++;
    pix_req = 1'b1; tick(1); pix_req = 1'b0;
    total_cnt++; if (underflow !== 1'b1) $display("FAIL uf_pulse got %b want 1", underflow); else pass_cnt++;
    total_cnt++; if (pixel !== 12'h0) $display("FAIL uf_pixel got %0h want 0", pixel); else pass_cnt++;
    tick(1);
    total_cnt++; if (underflow !== 1'b0) $display("FAIL uf_clear got %b want 0", underflow); else pass_cnt++;
    stall = 1'b0; ret_en = 1'b1; tick(1); stall = 1'b1;
    tick(40);
    for (int k = 0; k < 32; k++) begin
      total_cnt++;
      if (pixel !== pix(k)) $display("FAIL uf_refill_pix%0d got %0h want %0h", k, pixel, pix(k));
      else pass_cnt++;
      pix_req = 1'b1; tick(1);
    end
    pix_req = 1'b0;
    total_cnt++; if (pixel !== 12'h0) $display("FAIL uf_drained got %0h want 0", pixel); else pass_cnt++;
    pix_req = 1'b1; tick(1); pix_req = 1'b0; tick(1);
    total_cnt++; if (n_uf !== 2) $display("FAIL uf_count got %0d want 2", n_uf); else pass_cnt++;
    $display("underflow: %0d pulses", n_uf);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_write_priority();
    test_flush();
    test_stall();
    test_underflow();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
